// File: rtl/rr_arb_4x_nbit.sv
// Four-requester round-robin arbiter feeding a single registered output slot.
// A requester is accepted only when the slot is empty or being drained this cycle.
module rr_arb_4x_nbit #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    output logic [3:0]           gnt,
    output logic [1:0]           sel,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [1:0]           sel_q, sel_d;
    logic [BUS_WIDTH-1:0] y_q, y_d;

    logic       slot_free;
    logic       found;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;

    assign slot_free = (state_q == StEmpty) || y_ready;

    // Scan ptr, ptr+1, ... (2-bit add wraps 3 -> 0) for the first active request.
    always_comb begin
        gnt       = '0;
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + k[1:0];
            if (!found && req[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (found && slot_free && !reset) begin
            gnt[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        y_d     = y_q;
        if (|gnt) begin
            state_d = StFull;
            sel_d   = grant_idx;
            ptr_d   = grant_idx + 2'd1;
            unique case (grant_idx)
                2'd0:    y_d = a;
                2'd1:    y_d = b;
                2'd2:    y_d = c;
                default: y_d = d;
            endcase
        end else if (state_q == StFull && y_ready) begin
            // Drained with nothing to reload: y and sel keep their last values.
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            sel_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
        end
    end

    assign y       = y_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == StFull);

endmodule
